alarm_rtc: RTL

ALARM_RTC -- requirements
Module: alarm_rtc

---
 rtl/alarm_rtc.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alarm_rtc.sv
// Alarm real-time clock: tick-driven hh:mm:ss counter, Avalon register slave and alarm FSM.
// Define ALARM_RTC_SNOOZE_EN to build the SNOOZE state, snooze counter and register 5.
module alarm_rtc #(
   parameter int TICKS_PER_SEC = 1000,
   parameter int SNOOZE_MIN    = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tick_in,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq,
   output logic        alarm_out,
   output logic        sec_pulse,
   output logic [1:0]  dbg_state
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

`ifdef ALARM_RTC_SNOOZE_EN
   typedef enum logic [1:0] {ST_IDLE, ST_RINGING, ST_SNOOZE} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_RINGING} state_t;
`endif

   logic          r_tick_d;
   logic [PW-1:0] r_presc;
   logic [5:0]    r_sec;
   logic [5:0]    r_min;
   logic [4:0]    r_hour;
   logic [5:0]    r_al_min;
   logic [4:0]    r_al_hour;
   logic          r_run;
   logic          r_alarm_en;
   logic          r_irq_en;
   logic          r_sec_pulse;
   logic [15:0]   r_readdata;
   state_t        r_state;
   state_t        w_state_nxt;

   logic          w_tick;
   logic          w_wr;
   logic          w_hm_ok;
   logic          w_s_ok;
   logic          w_ld_hm;
   logic          w_ld_s;
   logic          w_ld_al;
   logic          w_wr_ctrl;
   logic          w_wr_stat;
   logic          w_sec_roll;
   logic          w_min_roll;
   logic          w_hour_roll;
   logic [5:0]    w_min_nxt;
   logic [4:0]    w_hour_nxt;
   logic          w_match;
   logic          w_ringing;
   logic          w_snoozing;
   logic [15:0]   w_rd;
   logic          w_unused_wd;

`ifdef ALARM_RTC_SNOOZE_EN
   logic [5:0]    r_snz;
   logic [5:0]    w_snz_nxt;
   logic          w_wr_snz;
`endif

   // Tick is the rising edge of the timer level; a held level counts once.
   assign w_tick      = tick_in & ~r_tick_d;
   assign w_wr        = chipselect & ~write_n;
   assign w_hm_ok     = (writedata[12:8] <= 5'd23) && (writedata[5:0] <= 6'd59);
   assign w_s_ok      = (writedata[5:0] <= 6'd59);
   assign w_ld_hm     = w_wr && (address == 3'd0) && w_hm_ok;
   assign w_ld_s      = w_wr && (address == 3'd1) && w_s_ok;
   assign w_ld_al     = w_wr && (address == 3'd2) && w_hm_ok;
   assign w_wr_ctrl   = w_wr && (address == 3'd3);
   assign w_wr_stat   = w_wr && (address == 3'd4);
   assign w_unused_wd = &{1'b0, writedata[15:13], writedata[7:6]};

   assign w_sec_roll  = r_run && w_tick && (r_presc == PRESC_MAX);
   assign w_min_roll  = w_sec_roll && (r_sec == 6'd59);
   assign w_hour_roll = w_min_roll && (r_min == 6'd59);
   assign w_min_nxt   = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
   assign w_hour_nxt  = !w_hour_roll ? r_hour : ((r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1);

   // Only a counted rollover onto hh:mm:00 can trigger; a loaded time never does.
   assign w_match = w_min_roll && !w_ld_hm && !w_ld_s && r_alarm_en &&
                    (w_hour_nxt == r_al_hour) && (w_min_nxt == r_al_min);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tick_d    <= 1'b0;
         r_presc     <= '0;
         r_sec       <= 6'd0;
         r_min       <= 6'd0;
         r_hour      <= 5'd0;
         r_sec_pulse <= 1'b0;
      end else begin
         r_tick_d    <= tick_in;
         r_sec_pulse <= w_sec_roll;
         if (w_ld_hm) begin
            r_hour  <= writedata[12:8];
            r_min   <= writedata[5:0];
            r_sec   <= 6'd0;
            r_presc <= '0;
         end else begin
            if (w_ld_s) begin
               r_sec   <= writedata[5:0];
               r_presc <= '0;
            end else if (r_run && w_tick) begin
               r_presc <= w_sec_roll ? '0 : r_presc + PW'(1);
               if (w_sec_roll)
                  r_sec <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
            end
            if (w_min_roll)
               r_min <= w_min_nxt;
            r_hour <= w_hour_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_al_hour  <= 5'd0;
         r_al_min   <= 6'd0;
         r_run      <= 1'b0;
         r_alarm_en <= 1'b0;
         r_irq_en   <= 1'b0;
      end else begin
         if (w_ld_al) begin
            r_al_hour <= writedata[12:8];
            r_al_min  <= writedata[5:0];
         end
         if (w_wr_ctrl)
            {r_irq_en, r_alarm_en, r_run} <= writedata[2:0];
      end
   end

`ifdef ALARM_RTC_SNOOZE_EN
   assign w_wr_snz = w_wr && (address == 3'd5);
`endif

   // Alarm FSM: a same-cycle match beats a STATUS clear; alarm_en=0 beats everything.
   always_comb begin
      w_state_nxt = r_state;
`ifdef ALARM_RTC_SNOOZE_EN
      w_snz_nxt   = r_snz;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_match)
               w_state_nxt = ST_RINGING;
         end
         ST_RINGING: begin
            if (!w_match) begin
               if (w_wr_stat && writedata[0])
                  w_state_nxt = ST_IDLE;
`ifdef ALARM_RTC_SNOOZE_EN
               else if (w_wr_snz) begin
                  w_state_nxt = ST_SNOOZE;
                  w_snz_nxt   = 6'(SNOOZE_MIN);
               end
`endif
            end
         end
`ifdef ALARM_RTC_SNOOZE_EN
         ST_SNOOZE: begin
            if (w_min_roll) begin
               if (r_snz <= 6'd1) begin
                  w_snz_nxt   = 6'd0;
                  w_state_nxt = ST_RINGING;
               end else begin
                  w_snz_nxt = r_snz - 6'd1;
               end
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_wr_ctrl && !writedata[1]) begin
         w_state_nxt = ST_IDLE;
`ifdef ALARM_RTC_SNOOZE_EN
         w_snz_nxt   = 6'd0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
`ifdef ALARM_RTC_SNOOZE_EN
         r_snz   <= 6'd0;
`endif
      end else begin
         r_state <= w_state_nxt;
`ifdef ALARM_RTC_SNOOZE_EN
         r_snz   <= w_snz_nxt;
`endif
      end
   end

   assign w_ringing  = (r_state == ST_RINGING);
`ifdef ALARM_RTC_SNOOZE_EN
   assign w_snoozing = (r_state == ST_SNOOZE);
`else
   assign w_snoozing = 1'b0;
`endif

   always_comb begin
      w_rd = 16'd0;
      case (address)
         3'd0: w_rd = {3'b0, r_hour, 2'b0, r_min};
         3'd1: w_rd = {10'b0, r_sec};
         3'd2: w_rd = {3'b0, r_al_hour, 2'b0, r_al_min};
         3'd3: w_rd = {13'b0, r_irq_en, r_alarm_en, r_run};
         3'd4: w_rd = {14'b0, w_snoozing, w_ringing};
`ifdef ALARM_RTC_SNOOZE_EN
         3'd5: w_rd = {10'b0, r_snz};
`endif
         default: w_rd = 16'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_readdata <= 16'd0;
      else
         r_readdata <= w_rd;
   end

   assign readdata  = r_readdata;
   assign sec_pulse = r_sec_pulse;
   assign alarm_out = w_ringing;
   assign irq       = w_ringing & r_irq_en;
   assign dbg_state = r_state;

endmodule
